// File: rtl/keycode_event_fifo_if.sv
// Event-stream bundle between the keycode filter/FIFO and its frame-rate consumer.
// The master side is the FIFO itself; the slave side drives the raw keycode and the handshake.
interface keycode_event_fifo_if #(
    parameter int DEPTH = 8
);
    logic [7:0]              keycode;
    logic                    ev_ready;
    logic                    clr_ovf;
    logic                    ev_valid;
    logic [7:0]              ev_code;
    logic                    ev_press;
    logic [7:0]              held_key;
    logic [$clog2(DEPTH):0]  count;
    logic                    overflow;

    modport master (
        input  keycode, ev_ready, clr_ovf,
        output ev_valid, ev_code, ev_press, held_key, count, overflow
    );

    modport slave (
        output keycode, ev_ready, clr_ovf,
        input  ev_valid, ev_code, ev_press, held_key, count, overflow
    );
endinterface

// File: rtl/keycode_event_fifo.sv
// Debounces the raw HID keycode, turns accepted level changes into press/release
// events and buffers them in a show-ahead FIFO with a sticky overflow flag.
module keycode_event_fifo #(
    parameter int STABLE_CYCLES = 4,
    parameter int DEPTH         = 8
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    keycode_event_fifo_if.master bus
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int AW = $clog2(DEPTH);
    localparam int NW = AW + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EMIT_REL = 2'd1,
        EMIT_PRS = 2'd2
    } state_e;

    typedef struct packed {
        logic       press;
        logic [7:0] code;
    } event_t;

    // Filter
    logic [7:0]    cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Event generator
    state_e        state_q, state_d;
    logic [7:0]    held_q, held_d;
    logic [7:0]    prev_q, prev_d;
    logic          push;
    event_t        push_ev;

    // FIFO
    event_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [NW-1:0] count_q;
    logic          ovf_q;
    logic          pop, full, wr_en, drop;
    event_t        head;

    // NOTE: every always_comb assigns its outputs a default first, so no path can infer a latch.
    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        if (bus.keycode != cand_q) begin
            cand_d = bus.keycode;
            cnt_d  = CW'(1);
        end else if (cnt_q != CW'(STABLE_CYCLES)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        held_d  = held_q;
        prev_d  = prev_q;
        push    = 1'b0;
        push_ev = '0;
        case (state_q)
            IDLE: begin
                if (cnt_q == CW'(STABLE_CYCLES) && cand_q != held_q) begin
                    held_d  = cand_q;
                    prev_d  = held_q;
                    state_d = (held_q != 8'h00) ? EMIT_REL : EMIT_PRS;
                end
            end
            EMIT_REL: begin
                push    = 1'b1;
                push_ev = '{press: 1'b0, code: prev_q};
                // held_q already carries the new key; a release to 0x00 has no press.
                state_d = (held_q != 8'h00) ? EMIT_PRS : IDLE;
            end
            EMIT_PRS: begin
                push    = 1'b1;
                push_ev = '{press: 1'b1, code: held_q};
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign full  = (count_q == NW'(DEPTH));
    assign pop   = (count_q != '0) && bus.ev_ready;
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cand_q   <= 8'h00;
            cnt_q    <= CW'(STABLE_CYCLES);
            state_q  <= IDLE;
            held_q   <= 8'h00;
            prev_q   <= 8'h00;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            held_q  <= held_d;
            prev_q  <= prev_d;
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({wr_en, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (drop)             ovf_q <= 1'b1;
            else if (bus.clr_ovf) ovf_q <= 1'b0;
        end
    end

    // NOTE: storage is not reset; empty-state outputs are masked by count, so stale entries never show.
    always_ff @(posedge Clk) begin
        if (wr_en) mem[wr_ptr_q] <= push_ev;
    end

    assign head         = mem[rd_ptr_q];
    assign bus.ev_valid = (count_q != '0);
    assign bus.ev_code  = bus.ev_valid ? head.code  : 8'h00;
    assign bus.ev_press = bus.ev_valid ? head.press : 1'b0;
    assign bus.held_key = held_q;
    assign bus.count    = count_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_keycode_event_fifo.sv
// Directed and randomized stimulus for keycode_event_fifo, checked every cycle
// against an event-list reference model.
module tb_keycode_event_fifo;

    localparam int STABLE = 4;
    localparam int DEPTH  = 8;

    logic clk;
    logic rst_n;

    keycode_event_fifo_if #(.DEPTH(DEPTH)) bus ();

    keycode_event_fifo #(.STABLE_CYCLES(STABLE), .DEPTH(DEPTH)) dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_asserts = 0;
    int n_fail    = 0;

    // Reference model: events as {press, code}
    logic [8:0] m_fifo    [$];
    logic [8:0] m_pending [$];
    logic [7:0] m_run_val;
    int         m_run_len;
    logic [7:0] m_held;
    logic       m_ovf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_fifo.delete();
        m_pending.delete();
        m_run_val = 8'h00;
        m_run_len = STABLE;
        m_held    = 8'h00;
        m_ovf     = 1'b0;
    endtask

    task automatic model_edge();
        logic       do_pop, have_push, do_drop;
        logic [8:0] ev;
        do_pop    = (m_fifo.size() != 0) && bus.ev_ready;
        have_push = 1'b0;
        ev        = '0;
        if (m_pending.size() != 0) begin
            ev        = m_pending.pop_front();
            have_push = 1'b1;
        end else if (m_run_len >= STABLE && m_run_val != m_held) begin
            if (m_held != 8'h00)    m_pending.push_back({1'b0, m_held});
            if (m_run_val != 8'h00) m_pending.push_back({1'b1, m_run_val});
            m_held = m_run_val;
        end
        do_drop = have_push && (m_fifo.size() == DEPTH) && !do_pop;
        if (do_pop) void'(m_fifo.pop_front());
        if (have_push && !do_drop) m_fifo.push_back(ev);
        if (do_drop)           m_ovf = 1'b1;
        else if (bus.clr_ovf)  m_ovf = 1'b0;
        if (bus.keycode == m_run_val) begin
            if (m_run_len < STABLE) m_run_len++;
        end else begin
            m_run_val = bus.keycode;
            m_run_len = 1;
        end
    endtask

    task automatic compare_all();
        logic [8:0] h;
        h = (m_fifo.size() != 0) ? m_fifo[0] : 9'h000;
        chk("ev_valid", 32'(bus.ev_valid), 32'(m_fifo.size() != 0));
        chk("ev_code",  32'(bus.ev_code),  32'(h[7:0]));
        chk("ev_press", 32'(bus.ev_press), 32'(h[8]));
        chk("count",    32'(bus.count),    32'(m_fifo.size()));
        chk("held_key", 32'(bus.held_key), 32'(m_held));
        chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    endtask

    // Inputs change only at negedge; the model advances on each posedge.
    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_edge();
        else       model_reset();
        @(negedge clk);
        compare_all();
    endtask

    task automatic hold(input logic [7:0] key, input int n);
        bus.keycode = key;
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        logic [7:0] keys [5];
        keys[0] = 8'h00; keys[1] = 8'h04; keys[2] = 8'h07; keys[3] = 8'h1A; keys[4] = 8'h29;

        rst_n        = 1'b0;
        bus.keycode  = 8'h00;
        bus.ev_ready = 1'b0;
        bus.clr_ovf  = 1'b0;
        model_reset();
        #1;
        compare_all();
        chk("reset_count", 32'(bus.count), 32'd0);

        // Press latency: 0x00 -> 0x04 held, nothing visible before edge 6
        @(negedge clk);
        rst_n       = 1'b1;
        bus.keycode = 8'h04;
        for (int i = 1; i <= 5; i++) begin
            cycle();
            chk("latency_no_event", 32'(bus.ev_valid), 32'd0);
        end
        cycle();
        chk("first_valid", 32'(bus.ev_valid), 32'd1);
        chk("first_code",  32'(bus.ev_code),  32'h04);
        chk("first_press", 32'(bus.ev_press), 32'd1);
        chk("first_count", 32'(bus.count),    32'd1);
        chk("first_held",  32'(bus.held_key), 32'h04);

        // Pop it, then key-to-key change 0x04 -> 0x07
        bus.ev_ready = 1'b1;
        cycle();
        bus.ev_ready = 1'b0;
        hold(8'h07, 7);
        chk("k2k_count", 32'(bus.count),    32'd2);
        chk("k2k_rel",   32'(bus.ev_press), 32'd0);
        chk("k2k_code0", 32'(bus.ev_code),  32'h04);
        bus.ev_ready = 1'b1;
        cycle();
        chk("k2k_pop1_count", 32'(bus.count),    32'd1);
        chk("k2k_prs",        32'(bus.ev_press), 32'd1);
        chk("k2k_code1",      32'(bus.ev_code),  32'h07);
        cycle();
        chk("k2k_pop2_count", 32'(bus.count),    32'd0);
        chk("k2k_empty",      32'(bus.ev_valid), 32'd0);

        // Release 0x07 (popped immediately), then a 3-sample glitch
        hold(8'h00, 8);
        bus.ev_ready = 1'b0;
        hold(8'h1A, 3);
        hold(8'h00, 8);
        chk("glitch_count", 32'(bus.count),    32'd0);
        chk("glitch_held",  32'(bus.held_key), 32'h00);

        // Overflow: ten events into an eight-deep FIFO
        for (int i = 0; i < 10; i++) hold((i % 2 == 0) ? 8'h04 : 8'h00, 8);
        chk("ovf_count", 32'(bus.count),    32'd8);
        chk("ovf_flag",  32'(bus.overflow), 32'd1);
        chk("ovf_head",  32'({bus.ev_press, bus.ev_code}), 32'h104);
        bus.clr_ovf = 1'b1;
        cycle();
        bus.clr_ovf = 1'b0;
        chk("ovf_cleared", 32'(bus.overflow), 32'd0);

        // Full FIFO: push and pop land on the same edge
        hold(8'h04, 5);
        bus.ev_ready = 1'b1;
        cycle();
        bus.ev_ready = 1'b0;
        chk("fullpp_count", 32'(bus.count),    32'd8);
        chk("fullpp_ovf",   32'(bus.overflow), 32'd0);
        bus.ev_ready = 1'b1;
        for (int i = 0; i < 7; i++) cycle();
        chk("fullpp_tail", 32'({bus.ev_press, bus.ev_code}), 32'h104);
        cycle();
        bus.ev_ready = 1'b0;

        // Build count=3 with a non-zero key held, then reset during EMIT_REL
        hold(8'h07, 8);
        hold(8'h04, 8);
        bus.ev_ready = 1'b1;
        cycle();
        bus.ev_ready = 1'b0;
        hold(8'h07, 5);
        chk("pre_reset_count", 32'(bus.count),    32'd3);
        chk("pre_reset_held",  32'(bus.held_key), 32'h07);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_count", 32'(bus.count),    32'd0);
        chk("rst_valid", 32'(bus.ev_valid), 32'd0);
        chk("rst_held",  32'(bus.held_key), 32'h00);
        chk("rst_ovf",   32'(bus.overflow), 32'd0);
        bus.keycode = 8'h00;
        cycle();
        @(negedge clk);
        rst_n = 1'b1;
        hold(8'h00, 10);
        chk("post_rst_quiet", 32'(bus.count), 32'd0);

        // Randomized keycodes, hold lengths, consumer and clear pulses
        for (int s = 0; s < 80; s++) begin
            bus.keycode = keys[$urandom_range(0, 4)];
            for (int c = 0, n = $urandom_range(1, 10); c < n; c++) begin
                bus.ev_ready = ($urandom_range(0, 3) == 0);
                bus.clr_ovf  = ($urandom_range(0, 15) == 0);
                cycle();
            end
        end
        bus.ev_ready = 1'b1;
        bus.clr_ovf  = 1'b0;
        hold(8'h00, 20);
        chk("final_drain", 32'(bus.count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
